sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the sram SDRAM controller. Port A (CPU) and port B (video/DMA)
//  issue req/ack transactions. The block serialises them with round-robin arbitration.
//  It drives the controller's level/edge rd/we strobes with fixed timing, holding off all grants until
//  SDRAM init completes. It returns captured read data with a one-cycle ack pulse.
// PARAMETERS
//  STARTUP_CYCLES  14'd10240  cycles after init before first grant (>= controller startup 10100)
//  ACCESS_CYCLES   6'd24      cycles mem_rd/mem_we held high per access (worst case incl. refresh slot, min 20)
//  GAP_CYCLES      3'd3       cycles both strobes held low between accesses (controller edge detect needs >=2)
// PORTS
//  clk_sdram  in   1   single clock, same 112MHz clock as the controller
//  init       in   1   synchronous active-high reset
//  a_req      in   1   port A request, level, held until a_ack
//  a_we       in   1   port A 1=write 0=read, valid with a_req
//  a_addr     in   24  port A word address
//  a_din      in   16  port A write data
//  a_wtbt     in   2   port A byte enables {hi,lo}, writes only
//  a_dout     out  16  port A read data, valid in a_ack cycle and held until next port A read ack
//  a_ack      out  1   port A completion pulse, 1 cycle
//  b_req, b_we, b_addr, b_din, b_wtbt, b_dout, b_ack   same as port A for port B
//  mem_addr   out  24  to controller addr
//  mem_din    out  16  to controller din
//  mem_wtbt   out  2   to controller wtbt
//  mem_we     out  1   to controller we
//  mem_rd     out  1   to controller rd
//  mem_dout   in   16  from controller dout
// BEHAVIOUR
//  Reset: all outputs 0; state=S_BOOT; counter=STARTUP_CYCLES; last_grant=B (A wins first tie).
//   init mid-access drops the strobes next cycle. No ack is issued and the pending request is discarded.
//   Requester re-requests since req is still high.
//  FSM:
//   S_BOOT: count down; at 0 -> S_IDLE. Requests are ignored (not lost; req is a level).
//   S_IDLE: sample a_req/b_req.
//    One active: grant it. Both active: grant the port not equal to last_grant.
//    On grant: latch the winner's addr/din/wtbt/we into mem_*; set mem_we=we, mem_rd=~we; counter=ACCESS_CYCLES-1.
//    Then update last_grant and go to S_ACCESS.
//   S_ACCESS: mem_* stable, strobe high. Counter decrements.
//    At 0: drop strobe. Copy mem_dout to winner's *_dout if read (write leaves *_dout unchanged).
//    Pulse winner's *_ack and go to S_GAP with counter=GAP_CYCLES-1.
//   S_GAP: strobes low, mem_addr/din/wtbt held. At counter 0 -> S_IDLE.
//  Latency: grant cycle + ACCESS_CYCLES to ack.
//   Back-to-back same port: next grant earliest GAP_CYCLES+1 cycles after ack.
//  Handshake: requester holds req/we/addr/din/wtbt stable until ack.
//   req high in the cycle after ack is a new request.
//   Changing fields while req is pending and before grant is legal; fields after grant are don't-care.
//  mem_rd and mem_we are never high together, never both high across a transition, and never re-asserted
//   without >=GAP_CYCLES low cycles.
//  Controller read-cache reuse (same addr repeated) is transparent: mem_dout is still sampled at window end.
//  Simultaneous a_req/b_req rising in S_ACCESS: both wait; next S_IDLE picks per round-robin.
//  Starvation bound: a pending port is served within one other access.
//  Counter widths are sized to the parameter widths; no wrap beyond the loaded values.
// TESTING
//  1 init high 1 cycle, a_req=1 read addr 24'h000100 at cycle 0 -> no mem_rd before STARTUP_CYCLES; first grant at STARTUP_CYCLES+1.
//  2 After boot: A write addr 24'h000010 din 16'hA5C3 wtbt 2'b11, then A read same addr -> a_dout=16'hA5C3 on ack, ack 24 cycles after grant.
//  3 Byte write wtbt 2'b01 din 16'h1234 over 16'hA5C3 -> read returns 16'hA534.
//  4 a_req,b_req both held high continuously -> grants alternate A,B,A,B; each ack 1 cycle; mem_rd/mem_we low >=3 cycles between.
//  5 init asserted at cycle 10 of an S_ACCESS read -> strobes 0 next cycle, no ack, re-boot; request completes after boot with correct data.
//  6 Reads forced onto controller refresh slot (idle 1500 cycles) -> data still correct, never both strobes high (assertion).

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the SDRAM controller.
// Serialises port A/B req/ack transactions into fixed-width rd/we strobe windows.
module sram_arbiter #(
  parameter logic [13:0] STARTUP_CYCLES = 14'd10240,
  parameter logic [5:0]  ACCESS_CYCLES  = 6'd24,
  parameter logic [2:0]  GAP_CYCLES     = 3'd3
) (
  input  logic        clk_sdram,
  input  logic        init,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [23:0] a_addr,
  input  logic [15:0] a_din,
  input  logic [1:0]  a_wtbt,
  output logic [15:0] a_dout,
  output logic        a_ack,

  input  logic        b_req,
  input  logic        b_we,
  input  logic [23:0] b_addr,
  input  logic [15:0] b_din,
  input  logic [1:0]  b_wtbt,
  output logic [15:0] b_dout,
  output logic        b_ack,

  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_wtbt,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [15:0] mem_dout
);

  localparam logic [1:0] S_BOOT   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  localparam logic [13:0] ACCESS_LOAD = {8'd0, ACCESS_CYCLES - 6'd1};
  localparam logic [13:0] GAP_LOAD    = {11'd0, GAP_CYCLES - 3'd1};

  logic [1:0]  state_q;
  logic [13:0] cnt_q;
  // Port of the most recent grant; also identifies the port owning the current window.
  logic        last_b_q;
  logic        grant_b;

  assign grant_b = b_req & (~a_req | ~last_b_q);

  always_ff @(posedge clk_sdram) begin
    if (init) begin
      state_q  <= S_BOOT;
      cnt_q    <= STARTUP_CYCLES;
      last_b_q <= 1'b1;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_wtbt <= '0;
      mem_we   <= 1'b0;
      mem_rd   <= 1'b0;
      a_dout   <= '0;
      a_ack    <= 1'b0;
      b_dout   <= '0;
      b_ack    <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state_q)
        S_BOOT: begin
          if (cnt_q == '0) state_q <= S_IDLE;
          else             cnt_q   <= cnt_q - 14'd1;
        end
        S_IDLE: begin
          if (a_req | b_req) begin
            last_b_q <= grant_b;
            mem_addr <= grant_b ? b_addr : a_addr;
            mem_din  <= grant_b ? b_din  : a_din;
            mem_wtbt <= grant_b ? b_wtbt : a_wtbt;
            mem_we   <= grant_b ? b_we   : a_we;
            mem_rd   <= grant_b ? ~b_we  : ~a_we;
            cnt_q    <= ACCESS_LOAD;
            state_q  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            mem_rd <= 1'b0;
            mem_we <= 1'b0;
            // mem_dout is sampled at window end even when the controller served from cache.
            if (last_b_q) begin
              b_ack <= 1'b1;
              if (mem_rd) b_dout <= mem_dout;
            end else begin
              a_ack <= 1'b1;
              if (mem_rd) a_dout <= mem_dout;
            end
            cnt_q   <= GAP_LOAD;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q - 14'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) state_q <= S_IDLE;
          else             cnt_q   <= cnt_q - 14'd1;
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised self-checking bench for sram_arbiter with a simple SDRAM controller model
// and a reference memory updated in ack order.
module tb_sram_arbiter;

  localparam int STARTUP = 10240;
  localparam int ACCESS  = 24;
  localparam int GAP     = 3;

  logic        clk_sdram = 1'b0;
  logic        init;
  logic        a_req, a_we, b_req, b_we;
  logic [23:0] a_addr, b_addr, mem_addr;
  logic [15:0] a_din, b_din, a_dout, b_dout, mem_din, mem_dout;
  logic [1:0]  a_wtbt, b_wtbt, mem_wtbt;
  logic        a_ack, b_ack, mem_we, mem_rd;

  always #4 clk_sdram = ~clk_sdram;

  sram_arbiter dut (
    .clk_sdram (clk_sdram),
    .init      (init),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_din     (a_din),
    .a_wtbt    (a_wtbt),
    .a_dout    (a_dout),
    .a_ack     (a_ack),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_din     (b_din),
    .b_wtbt    (b_wtbt),
    .b_dout    (b_dout),
    .b_ack     (b_ack),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_wtbt  (mem_wtbt),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .mem_dout  (mem_dout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Controller model: data valid some cycles into the window, later after long idle (refresh).
  logic [15:0] ctrl_mem [1024];
  logic [15:0] ref_mem  [1024];
  int busy = 0;
  int lat = 0;
  int idle_cnt = 0;

  always @(posedge clk_sdram) begin
    if (mem_rd | mem_we) begin
      if (busy == 0) lat <= (idle_cnt > 1000 || $urandom_range(3) == 0) ? 22 : 12;
      if (mem_we && busy == 5) begin
        if (mem_wtbt[1]) ctrl_mem[mem_addr[9:0]][15:8] <= mem_din[15:8];
        if (mem_wtbt[0]) ctrl_mem[mem_addr[9:0]][7:0]  <= mem_din[7:0];
      end
      busy     <= busy + 1;
      idle_cnt <= 0;
    end else begin
      busy     <= 0;
      idle_cnt <= idle_cnt + 1;
    end
  end

  assign mem_dout = (mem_rd && busy > 0 && busy >= lat) ? ctrl_mem[mem_addr[9:0]] : 16'hDEAD;

  // Protocol monitor
  int cyc = 0;
  int reset_cyc = 0;
  int rise_cyc = 0;
  int ack_cyc = 0;
  int low_run = 0;
  int high_run = 0;
  bit boot_pending = 0;
  bit aborted = 0;
  bit prev_strobe = 0;
  bit prev_a = 0;
  bit prev_b = 0;
  bit strobe;
  bit ack_q[$];

  always @(posedge clk_sdram) begin
    if (init) begin
      reset_cyc    = cyc;
      boot_pending = 1;
      if (mem_rd | mem_we) aborted = 1;
    end
  end

  always @(negedge clk_sdram) begin
    cyc++;
    strobe = mem_rd | mem_we;
    if (mem_rd && mem_we) check_eq("strobes_both_high", {30'd0, mem_rd, mem_we}, 32'd0);
    if (strobe && !prev_strobe) begin
      if (boot_pending) begin
        check_eq("boot_holdoff", 32'((cyc - reset_cyc) >= STARTUP + 1 &&
                                     (cyc - reset_cyc) <= STARTUP + 3), 32'd1);
        boot_pending = 0;
      end else begin
        check_eq("gap_low_cycles", 32'(low_run >= GAP), 32'd1);
      end
      rise_cyc = cyc;
      high_run = 0;
    end
    if (!strobe && prev_strobe) begin
      if (!aborted) check_eq("strobe_len", 32'(high_run), 32'(ACCESS));
      aborted = 0;
      low_run = 0;
    end
    if (strobe) high_run++;
    else        low_run++;
    if (a_ack || b_ack) begin
      check_eq("ack_latency", 32'(cyc - rise_cyc), 32'(ACCESS));
      check_eq("ack_pulse", {29'd0, a_ack & b_ack, a_ack & prev_a, b_ack & prev_b}, 32'd0);
      ack_q.push_back(b_ack);
      ack_cyc = cyc;
    end
    prev_strobe = strobe;
    prev_a      = a_ack;
    prev_b      = b_ack;
  end

  // One transaction on a port; reference memory is updated at ack, i.e. in service order.
  task automatic xfer(input bit port, input bit we, input logic [23:0] addr,
                      input logic [15:0] din, input logic [1:0] wtbt, input int budget,
                      output logic [15:0] rdata);
    int n;
    bit got;
    int idx;
    idx = int'(addr[9:0]);
    if (port) begin
      b_we = we; b_addr = addr; b_din = din; b_wtbt = wtbt; b_req = 1'b1;
    end else begin
      a_we = we; a_addr = addr; a_din = din; a_wtbt = wtbt; a_req = 1'b1;
    end
    n = 0;
    got = 0;
    while (!got && n < budget) begin
      @(negedge clk_sdram);
      n++;
      got = port ? b_ack : a_ack;
    end
    check_eq(port ? "b_ack_seen" : "a_ack_seen", 32'(got), 32'd1);
    rdata = port ? b_dout : a_dout;
    if (got) begin
      if (we) begin
        if (wtbt[1]) ref_mem[idx][15:8] = din[15:8];
        if (wtbt[0]) ref_mem[idx][7:0]  = din[7:0];
      end else begin
        check_eq(port ? "b_read_data" : "a_read_data", 32'(rdata), 32'(ref_mem[idx]));
      end
    end
    @(posedge clk_sdram);
    #1;
    if (port) b_req = 1'b0;
    else      a_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] rd;
  bit last_port;
  int init_cyc;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ctrl_mem[i] = 16'h0000;
      ref_mem[i]  = 16'h0000;
    end
    init = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_din = 0; a_wtbt = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_din = 0; b_wtbt = 0;

    // Boot: request pending from the start, held off until startup count expires.
    fork
      xfer(1'b0, 1'b0, 24'h000100, 16'h0000, 2'b00, 20000, rd);
      begin
        @(posedge clk_sdram);
        #1 init = 1'b0;
        @(negedge clk_sdram);
        check_eq("rst_strobes_acks", {28'd0, mem_rd, mem_we, a_ack, b_ack}, 32'd0);
        check_eq("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
        check_eq("rst_douts", {a_dout, b_dout}, 32'd0);
        check_eq("rst_mem_din_wtbt", {14'd0, mem_din, mem_wtbt}, 32'd0);
      end
    join

    // Full write then read back; then byte-lane write.
    xfer(1'b0, 1'b1, 24'h000010, 16'hA5C3, 2'b11, 200, rd);
    xfer(1'b0, 1'b0, 24'h000010, 16'h0000, 2'b00, 200, rd);
    check_eq("t2_read_back", 32'(rd), 32'h0000A5C3);
    xfer(1'b0, 1'b1, 24'h000010, 16'h1234, 2'b01, 200, rd);
    xfer(1'b0, 1'b0, 24'h000010, 16'h0000, 2'b00, 200, rd);
    check_eq("t3_byte_write", 32'(rd), 32'h0000A534);

    // Both ports requesting continuously: service must alternate.
    last_port = ack_q[ack_q.size() - 1];
    ack_q.delete();
    fork
      begin : a_burst
        logic [15:0] r;
        for (int i = 0; i < 4; i++)
          xfer(1'b0, 1'(i % 2), 24'h000020 + 24'(i), 16'(16'h1100 + i), 2'b11, 200, r);
      end
      begin : b_burst
        logic [15:0] r;
        for (int i = 0; i < 4; i++)
          xfer(1'b1, 1'((i + 1) % 2), 24'h000030 + 24'(i), 16'(16'h2200 + i), 2'b11, 200, r);
      end
    join
    check_eq("rr_count", 32'(ack_q.size()), 32'd8);
    if (ack_q.size() == 8) begin
      check_eq("rr_first", 32'(ack_q[0]), 32'(!last_port));
      for (int i = 1; i < 8; i++) check_eq("rr_alternate", 32'(ack_q[i]), 32'(!ack_q[i - 1]));
    end

    // init during a read window: strobe drops, no ack until after reboot, data still right.
    fork
      xfer(1'b0, 1'b0, 24'h000010, 16'h0000, 2'b00, 25000, rd);
      begin
        for (int n = 0; n < 100 && !mem_rd; n++) @(negedge clk_sdram);
        repeat (10) @(posedge clk_sdram);
        #1 init = 1'b1;
        @(posedge clk_sdram);
        init_cyc = cyc;
        #1 init = 1'b0;
        @(negedge clk_sdram);
        check_eq("abort_strobe_low", {30'd0, mem_rd, mem_we}, 32'd0);
        check_eq("abort_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
      end
    join
    check_eq("ack_after_reboot", 32'((ack_cyc - init_cyc) > STARTUP), 32'd1);
    check_eq("t5_read_data", 32'(rd), 32'h0000A534);

    // Long idle so reads land on the slow refresh-slot path.
    repeat (1500) @(posedge clk_sdram);
    #1;
    xfer(1'b1, 1'b0, 24'h000010, 16'h0000, 2'b00, 200, rd);
    xfer(1'b0, 1'b0, 24'h000022, 16'h0000, 2'b00, 200, rd);
    xfer(1'b0, 1'b0, 24'h000022, 16'h0000, 2'b00, 200, rd);

    // Random mixed traffic on both ports over a small shared address window.
    fork
      begin : a_rand
        logic [15:0] r;
        int g;
        for (int i = 0; i < 20; i++) begin
          xfer(1'b0, 1'($urandom_range(1)), 24'h000010 + 24'($urandom_range(7)),
               16'($urandom), 2'($urandom_range(1, 3)), 200, r);
          g = $urandom_range(0, 5);
          repeat (g) begin @(posedge clk_sdram); #1; end
        end
      end
      begin : b_rand
        logic [15:0] r;
        int g;
        for (int i = 0; i < 20; i++) begin
          xfer(1'b1, 1'($urandom_range(1)), 24'h000010 + 24'($urandom_range(7)),
               16'($urandom), 2'($urandom_range(1, 3)), 200, r);
          g = $urandom_range(0, 5);
          repeat (g) begin @(posedge clk_sdram); #1; end
        end
      end
    join

    repeat (10) @(posedge clk_sdram);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
